pll_dyn_ctrl: RTL

Sequencer for the Gowin rPLL that generates the LCD pixel clock from the 27 MHz crystal. It runs the PLL reset/lock sequence and drives the rPLL dynamic divider selects (IDSEL/FBDSEL/ODSEL) so the pixel clock can be retargeted at runtime, for example 9 MHz for 480x272 or 33 MHz for 800x480. It qualifies LOCK, handles lock loss and retries, and holds the pixel-domain reset until the clock is stable. It runs entirely on the crystal clock, never on the PLL output.

---
 rtl/pll_dyn_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pll_dyn_ctrl.sv
// Gowin rPLL reset/lock sequencer with runtime IDSEL/FBDSEL/ODSEL retargeting.
// Runs on the crystal clock only; LOCK is synchronised and qualified before use.
module pll_dyn_ctrl #(
    parameter logic [5:0] DEF_IDSEL      = 6'd0,
    parameter logic [5:0] DEF_FBDSEL     = 6'd0,
    parameter logic [5:0] DEF_ODSEL      = 6'd0,
    parameter int         RST_CYCLES     = 16,
    parameter int         STABLE_CYCLES  = 1024,
    parameter int         TIMEOUT_CYCLES = 270000,
    parameter int         MAX_RETRY      = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cfg_valid,
    output logic       o_cfg_ready,
    input  logic [5:0] i_cfg_idsel,
    input  logic [5:0] i_cfg_fbdsel,
    input  logic [5:0] i_cfg_odsel,
    output logic [5:0] o_pll_idsel,
    output logic [5:0] o_pll_fbdsel,
    output logic [5:0] o_pll_odsel,
    output logic       o_pll_reset,
    input  logic       i_pll_lock,
    output logic       o_pix_rst,
    output logic       o_locked,
    output logic       o_fault,
    output logic [7:0] o_relock_cnt
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int QW = $clog2(MAX_RETRY + 1);

    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = '1;

    localparam logic [2:0] S_RST_PLL   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic          r_lock_meta;
    logic          r_lock_s;
    logic [RW-1:0] r_rst_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic [SW-1:0] r_stb_cnt;
    logic [QW-1:0] r_retry;
    logic [7:0]    r_relock_cnt;
    logic [5:0]    r_idsel;
    logic [5:0]    r_fbdsel;
    logic [5:0]    r_odsel;
    logic          r_pll_reset;
    logic          r_pix_rst;
    logic          r_locked;
    logic          r_fault;
    logic          r_cfg_ready;
    logic          w_xfer;
    logic          w_retry_ok;
    logic          w_timeout;

    // Next-state decode; a cfg transfer always wins over a simultaneous lock loss
    always_comb begin
        w_xfer      = i_cfg_valid & r_cfg_ready;
        w_retry_ok  = (int'(r_retry) + 32'sd1) < MAX_RETRY;
        w_timeout   = (r_tmo_cnt >= TMO_LAST);
        w_state_nxt = S_RST_PLL;
        case (r_state)
            S_RST_PLL: begin
                if (r_rst_cnt == RST_LAST) w_state_nxt = S_WAIT_LOCK;
                else                       w_state_nxt = S_RST_PLL;
            end
            S_WAIT_LOCK: begin
                if (r_lock_s)        w_state_nxt = S_STABLE;
                else if (!w_timeout) w_state_nxt = S_WAIT_LOCK;
                else if (w_retry_ok) w_state_nxt = S_RST_PLL;
                else                 w_state_nxt = S_FAULT;
            end
            S_STABLE: begin
                if (!r_lock_s)                  w_state_nxt = S_WAIT_LOCK;
                else if (r_stb_cnt == STB_LAST) w_state_nxt = S_RUN;
                else                            w_state_nxt = S_STABLE;
            end
            S_RUN: begin
                if (w_xfer)         w_state_nxt = S_RST_PLL;
                else if (!r_lock_s) w_state_nxt = S_WAIT_LOCK;
                else                w_state_nxt = S_RUN;
            end
            S_FAULT: begin
                if (w_xfer) w_state_nxt = S_RST_PLL;
                else        w_state_nxt = S_FAULT;
            end
            default: w_state_nxt = S_RST_PLL;
        endcase
    end

    // State, counters, divider codes and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_RST_PLL;
            r_lock_meta  <= 1'b0;
            r_lock_s     <= 1'b0;
            r_rst_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_stb_cnt    <= '0;
            r_retry      <= '0;
            r_relock_cnt <= 8'd0;
            r_idsel      <= DEF_IDSEL;
            r_fbdsel     <= DEF_FBDSEL;
            r_odsel      <= DEF_ODSEL;
            r_pll_reset  <= 1'b1;
            r_pix_rst    <= 1'b1;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
            r_cfg_ready  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_meta <= i_pll_lock;
            r_lock_s    <= r_lock_meta;

            if (r_state == S_RST_PLL && w_state_nxt == S_RST_PLL) r_rst_cnt <= r_rst_cnt + RW'(1'b1);
            else                                                   r_rst_cnt <= '0;

            // Timeout spans the whole acquisition attempt, including bounces through STABLE
            if (r_state == S_WAIT_LOCK || r_state == S_STABLE) begin
                if (r_tmo_cnt != TMO_MAX) r_tmo_cnt <= r_tmo_cnt + TW'(1'b1);
            end else begin
                r_tmo_cnt <= '0;
            end

            if (r_state == S_STABLE && r_lock_s) r_stb_cnt <= r_stb_cnt + SW'(1'b1);
            else                                 r_stb_cnt <= '0;

            if (r_state == S_WAIT_LOCK && w_state_nxt == S_RST_PLL)  r_retry <= r_retry + QW'(1'b1);
            else if (w_state_nxt == S_RUN && r_state == S_STABLE)    r_retry <= '0;
            else if (r_state == S_RUN && w_state_nxt == S_WAIT_LOCK) r_retry <= '0;
            else if (r_state == S_FAULT && w_xfer)                   r_retry <= '0;

            if (r_state == S_RUN && w_state_nxt == S_WAIT_LOCK && r_relock_cnt != 8'hFF)
                r_relock_cnt <= r_relock_cnt + 8'd1;

            if (w_xfer) begin
                r_idsel  <= i_cfg_idsel;
                r_fbdsel <= i_cfg_fbdsel;
                r_odsel  <= i_cfg_odsel;
            end

            r_pll_reset <= (w_state_nxt == S_RST_PLL) || (w_state_nxt == S_FAULT);
            r_pix_rst   <= (w_state_nxt != S_RUN);
            r_locked    <= (w_state_nxt == S_RUN);
            r_fault     <= (w_state_nxt == S_FAULT);
            r_cfg_ready <= (w_state_nxt == S_RUN) || (w_state_nxt == S_FAULT);
        end
    end

    assign o_cfg_ready  = r_cfg_ready;
    assign o_pll_idsel  = r_idsel;
    assign o_pll_fbdsel = r_fbdsel;
    assign o_pll_odsel  = r_odsel;
    assign o_pll_reset  = r_pll_reset;
    assign o_pix_rst    = r_pix_rst;
    assign o_locked     = r_locked;
    assign o_fault      = r_fault;
    assign o_relock_cnt = r_relock_cnt;
endmodule
